// File: rtl/cart_bus_if.sv
// Sequences one core bus transaction at a time onto the cartridge pins with
// programmable setup/strobe/hold/turnaround timing; all pin outputs are registered.
module cart_bus_if #(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 6,
  parameter int HOLD_CYC   = 2,
  parameter int TURN_CYC   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        ack,
  output logic        busy,
  output logic [15:0] cart_a,
  output logic [7:0]  cart_d_out,
  output logic        cart_d_oe,
  input  logic [7:0]  cart_d_in,
  output logic        cart_rd_n,
  output logic        cart_wr_n,
  output logic        cart_cs_n
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_TURN
  } state_t;

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);
  localparam logic [3:0] TURN_LD   = 4'(TURN_CYC - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [7:0]  wdata_q, wdata_d;

  logic [7:0]  rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        busy_q, busy_d;
  logic [15:0] cart_a_q, cart_a_d;
  logic [7:0]  d_out_q, d_out_d;
  logic        d_oe_q, d_oe_d;
  logic        rd_n_q, rd_n_d;
  logic        wr_n_q, wr_n_d;
  logic        cs_n_q, cs_n_d;
  logic        active;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_SETUP;
          cnt_d   = SETUP_LD;
          addr_d  = addr;
          we_d    = we;
          wdata_d = wdata;
        end
      end
      S_SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = S_STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_STROBE: begin
        if (cnt_q == 4'd0) begin
          // Zero-length HOLD/TURN phases fall straight through to the next one.
          if (HOLD_CYC > 0) begin
            state_d = S_HOLD;
            cnt_d   = HOLD_LD;
          end else if (TURN_CYC > 0) begin
            state_d = S_TURN;
            cnt_d   = TURN_LD;
          end else begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == 4'd0) begin
          if (TURN_CYC > 0) begin
            state_d = S_TURN;
            cnt_d   = TURN_LD;
          end else begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_TURN: begin
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Pin values are derived from the next state so they appear in the same cycle as it.
  always_comb begin
    active   = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
    ack_d    = (state_q != S_IDLE) && (state_d == S_IDLE);
    busy_d   = (state_d != S_IDLE);
    cart_a_d = active ? addr_d : cart_a_q;
    cs_n_d   = !(active && (addr_d[15:13] == 3'b101));
    rd_n_d   = !(active && !we_d);
    wr_n_d   = !((state_d == S_STROBE) && we_d);
    d_oe_d   = active && we_d;
    d_out_d  = (active && we_d) ? wdata_d : d_out_q;
    rdata_d  = ((state_q == S_STROBE) && (cnt_q == 4'd0) && !we_q) ? cart_d_in : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= 16'd0;
      we_q     <= 1'b0;
      wdata_q  <= 8'd0;
      rdata_q  <= 8'd0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      cart_a_q <= 16'd0;
      d_out_q  <= 8'd0;
      d_oe_q   <= 1'b0;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      cs_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      cart_a_q <= cart_a_d;
      d_out_q  <= d_out_d;
      d_oe_q   <= d_oe_d;
      rd_n_q   <= rd_n_d;
      wr_n_q   <= wr_n_d;
      cs_n_q   <= cs_n_d;
    end
  end

  assign rdata      = rdata_q;
  assign ack        = ack_q;
  assign busy       = busy_q;
  assign cart_a     = cart_a_q;
  assign cart_d_out = d_out_q;
  assign cart_d_oe  = d_oe_q;
  assign cart_rd_n  = rd_n_q;
  assign cart_wr_n  = wr_n_q;
  assign cart_cs_n  = cs_n_q;

endmodule
